// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;

    // Store data arrives right-aligned; copy it into every lane so the byte
    // enables alone decide which lanes land in the array.
    function automatic logic [31:0] replicate_wdata(input size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_B:    return {4{wd[7:0]}};
            SZ_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_dec.sv
// Byte-lane decoder: request size + low address bits -> byte enables, misalign flag.
// Latency: combinational.
// Backpressure: none.
// Ports: size_i (access size), addr_lo_i (addr[1:0]), be_o (4 lane enables),
//        misaligned_o (half on odd byte, word off word boundary, or reserved size).
module dmem_lane_dec
    import dmem_pkg::*;
(
    input  size_e      size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] be_o,
    output logic       misaligned_o
);

    always_comb begin
        be_o         = 4'b1111;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_B: be_o = 4'b0001 << addr_lo_i;
            SZ_H: begin
                // Half lanes follow addr[1] only; addr[0] just flags misalignment.
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            SZ_W:    misaligned_o = (addr_lo_i != 2'b00);
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time on a byte-addressable word array.
// Latency: response pulse LATENCY cycles after accept (accept edge E0, rsp sampled high at E(LATENCY)).
// Backpressure: req_ready low while a request waits; stall = req_valid & ~req_ready.
// Ports: clk, reset (async, active-low); req_valid/req_ready handshake with
//        req_write, req_size, req_addr, req_wdata; rsp_valid pulse with rsp_rdata, rsp_err;
//        stall to the core hazard logic.
// Build option: DMEM_MISALIGN_CHK_EN enables misaligned-access detection (no write, rsp_err=1).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;          // response data captured at accept
    logic        hold_err_q, hold_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic             misaligned;
    logic             bad;
    logic             wr_en;
    logic [31:0]      wdata_rep;
    logic [31:0]      acc_rdata;

    assign req_ready = (state_q != S_WAIT);
    assign accept    = req_valid & req_ready;
    assign stall     = req_valid & ~req_ready;
    assign idx       = req_addr[2 +: IDX_W];   // upper bits dropped: addresses wrap

    dmem_lane_dec u_lane_dec (
        .size_i       (size_e'(req_size)),
        .addr_lo_i    (req_addr[1:0]),
        .be_o         (be),
        .misaligned_o (misaligned)
    );

`ifdef DMEM_MISALIGN_CHK_EN
    assign bad = misaligned;
    logic unused_ok;
    assign unused_ok = &{1'b0, req_addr[31:IDX_W+2]};
`else
    assign bad = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, req_addr[31:IDX_W+2], misaligned};
`endif

    assign wr_en     = accept & req_write & ~bad;
    assign wdata_rep = replicate_wdata(size_e'(req_size), req_wdata);
    // Stores and rejected accesses answer with zero data.
    assign acc_rdata = (req_write | bad) ? 32'd0 : mem_q[idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_err_d = hold_err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                if (accept) begin
                    hold_d     = acc_rdata;
                    hold_err_d = bad;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // WAIT lasts LATENCY-1 cycles: counts LATENCY-1 down to 1.
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they are clean in RESP only.
        rsp_valid_d = (state_d == S_RESP);
        rsp_rdata_d = rsp_valid_d ? hold_d : 32'd0;
        rsp_err_d   = rsp_valid_d & hold_err_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hold_q      <= 32'd0;
            hold_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_err_q  <= hold_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is never reset; committed writes survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
